// File: rtl/sonic_scanner.sv
// rtl/sonic_scanner.sv - multi-channel ultrasonic ranging sequencer
//
// Purpose: sweeps the enabled ultrasonic channels in ascending order. For each
// channel it drives a trigger pulse on the shared bidirectional sensor line,
// waits out the ring-down holdoff, then times the echo high phase.
//
// Optional feature: define SONIC_SCANNER_FILTER_EN to average each successful
// result with the previous one for that channel.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   req       in   start one sweep (sampled in IDLE only)
//   cont      in   keep sweeping back-to-back while high
//   ch_mask   in   [NCH] channel enables, latched at sweep start
//   sig       io   [NCH] sensor lines: trigger out, echo in
//   busy      out  FSM not in IDLE
//   done      out  one-cycle pulse at end of each sweep
//   out_data  out  [NCH*W] per-channel echo length, channel n at [n*W +: W]
//   timeout   out  [NCH] last attempt saw no echo rise
//   ovr       out  [NCH] last attempt saturated at T_ECHO_MAX
module sonic_scanner #(
  parameter int NCH        = 4,
  parameter int W          = 32,
  parameter int T_PULSE    = 500,
  parameter int T_HOLDOFF  = 75000,
  parameter int T_START_TO = 2000,
  parameter int T_ECHO_MAX = 1850000,
  parameter int T_GAP      = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             cont,
  input  logic [NCH-1:0]   ch_mask,
  inout  wire  [NCH-1:0]   sig,
  output logic             busy,
  output logic             done,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH-1:0]   timeout,
  output logic [NCH-1:0]   ovr
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [31:0] PULSE_LAST = 32'(T_PULSE - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(T_HOLDOFF - 1);
  localparam logic [31:0] START_LAST = 32'(T_START_TO - 1);
  localparam logic [31:0] GAP_LAST   = 32'(T_GAP - 1);

  // Saturation limit clipped to what a W-bit count can hold, so the count
  // stops before it could ever wrap.
  localparam longint unsigned W_MAX    = (W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                   : ((64'd1 << W) - 64'd1);
  localparam longint unsigned LIM_WIDE = (64'(T_ECHO_MAX) > W_MAX) ? W_MAX
                                                                   : 64'(T_ECHO_MAX);
  localparam logic [W-1:0]    ECHO_LIM = LIM_WIDE[W-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_HOLDOFF, S_WAIT_RISE, S_MEASURE, S_GAP, S_NEXT
  } state_t;

  state_t             state_q, state_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [31:0]        tmr_q, tmr_d;
  logic [W-1:0]       meas_q, meas_d;
  logic [NCH-1:0]     sync1_q, sync1_d;
  logic [NCH-1:0]     sync2_q, sync2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NCH*W-1:0]   data_q, data_d;
  logic [NCH-1:0]     to_q, to_d;
  logic [NCH-1:0]     ovr_q, ovr_d;
`ifdef SONIC_SCANNER_FILTER_EN
  logic [NCH-1:0]     seen_q, seen_d;
  logic [W:0]         sum;
`endif

  logic               echo;
  logic               fin_ok;
  logic               fin_sat;
  logic [NCH-1:0]     higher;
  int                 base;

  function automatic logic [CHW-1:0] lowest(input logic [NCH-1:0] m);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest = CHW'(i);
    end
  endfunction

  // Enabled channels strictly above channel c.
  function automatic logic [NCH-1:0] above(input logic [NCH-1:0] m, input logic [CHW-1:0] c);
    above = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m[i] && (i > int'(c))) above[i] = 1'b1;
    end
  endfunction

  // Trigger is the only time the block drives the line; otherwise it listens.
  for (genvar g = 0; g < NCH; g++) begin : g_drv
    assign sig[g] = (state_q == S_PULSE && int'(ch_q) == g) ? 1'b1 : 1'bz;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    tmr_d   = tmr_q;
    meas_d  = meas_q;
    data_d  = data_q;
    to_d    = to_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    sync1_d = sig;
    sync2_d = sync1_q;
    fin_ok  = 1'b0;
    fin_sat = 1'b0;
    echo    = sync2_q[ch_q];
    base    = int'(ch_q) * W;
    higher  = above(mask_q, ch_q);
`ifdef SONIC_SCANNER_FILTER_EN
    seen_d  = seen_q;
    sum     = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req && ch_mask != '0) begin
          mask_d  = ch_mask;
          ch_d    = lowest(ch_mask);
          tmr_d   = '0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (tmr_q == PULSE_LAST) begin
          tmr_d   = '0;
          state_d = S_HOLDOFF;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_HOLDOFF: begin
        if (tmr_q == HOLD_LAST) begin
          tmr_d   = '0;
          state_d = S_WAIT_RISE;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_WAIT_RISE: begin
        if (echo) begin
          // The rising-edge cycle is itself the first high cycle counted.
          meas_d = W'(1);
          tmr_d  = '0;
          if (ECHO_LIM <= W'(1)) begin
            fin_sat = 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_MEASURE;
          end
        end else if (tmr_q == START_LAST) begin
          to_d[ch_q]  = 1'b1;
          ovr_d[ch_q] = 1'b0;
          tmr_d       = '0;
          state_d     = S_GAP;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_MEASURE: begin
        if (echo) begin
          if (meas_q + W'(1) == ECHO_LIM) begin
            fin_sat = 1'b1;
            state_d = S_GAP;
          end else begin
            meas_d = meas_q + W'(1);
          end
        end else begin
          fin_ok  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = S_NEXT;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_NEXT: begin
        if (higher != '0) begin
          ch_d    = lowest(higher);
          state_d = S_PULSE;
        end else begin
          done_d = 1'b1;
          if (cont && ch_mask != '0) begin
            mask_d  = ch_mask;
            ch_d    = lowest(ch_mask);
            state_d = S_PULSE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin_sat) begin
      data_d[base +: W] = ECHO_LIM;
      ovr_d[ch_q]       = 1'b1;
      to_d[ch_q]        = 1'b0;
    end

    if (fin_ok) begin
`ifdef SONIC_SCANNER_FILTER_EN
      // Averaged at W+1 bits so the sum cannot overflow before the shift.
      sum = {1'b0, data_q[base +: W]} + {1'b0, meas_q};
      data_d[base +: W] = seen_q[ch_q] ? W'(sum >> 1) : meas_q;
      seen_d[ch_q]      = 1'b1;
`else
      data_d[base +: W] = meas_q;
`endif
      ovr_d[ch_q] = 1'b0;
      to_d[ch_q]  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      mask_q  <= '0;
      tmr_q   <= '0;
      meas_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      to_q    <= '0;
      ovr_q   <= '0;
`ifdef SONIC_SCANNER_FILTER_EN
      seen_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      tmr_q   <= tmr_d;
      meas_q  <= meas_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
`ifdef SONIC_SCANNER_FILTER_EN
      seen_q  <= seen_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = data_q;
  assign timeout  = to_q;
  assign ovr      = ovr_q;

endmodule

// File: doc/sonic_scanner.md
SONIC_SCANNER -- requirements
Module: sonic_scanner

Interface
REQ-001 SHALL have parameter NCH, default 4: number of ultrasonic channels, range 1..8.
REQ-002 SHALL have parameter W, default 32: result width per channel.
REQ-003 SHALL have parameter T_PULSE, default 500: trigger pulse length in clk cycles.
REQ-004 SHALL have parameter T_HOLDOFF, default 75000: cycles between trigger end and echo listen.
REQ-005 SHALL have parameter T_START_TO, default 2000: cycles allowed for the echo rising edge.
REQ-006 SHALL have parameter T_ECHO_MAX, default 1850000: echo saturation limit in cycles.
REQ-007 SHALL have parameter T_GAP, default 20000: cycles between channel measurements.
REQ-008 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-009 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-010 SHALL have port req, input, 1: start one sweep; sampled only in IDLE.
REQ-011 SHALL have port cont, input, 1: repeat sweeps while high.
REQ-012 SHALL have port ch_mask, input, NCH: channel enables, sampled at sweep start.
REQ-013 SHALL have port sig, inout, NCH: per-channel sensor line.
REQ-014 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at sweep end.
REQ-016 SHALL have port out_data, output, NCH*W: channel n result at bits [n*W +: W].
REQ-017 SHALL have port timeout, output, NCH: per-channel no-echo flag from the last attempt.
REQ-018 SHALL have port ovr, output, NCH: per-channel echo-saturated flag from the last attempt.

Function
REQ-019 SHALL use FSM states IDLE, PULSE, HOLDOFF, WAIT_RISE, MEASURE, GAP, NEXT.
REQ-020 IDLE->PULSE SHALL occur on req=1 with ch_mask!=0; the sweep SHALL begin at the lowest enabled channel; req with ch_mask=0 SHALL be ignored.
REQ-021 In PULSE, sig[ch] SHALL be driven 1 for exactly T_PULSE cycles; all other sig bits, and sig[ch] in every other state, SHALL be Z.
REQ-022 HOLDOFF SHALL last exactly T_HOLDOFF cycles, then enter WAIT_RISE.
REQ-023 sig[ch] SHALL be read through a 2-flop synchroniser; all echo timings SHALL refer to the synchronised value, a fixed 2-cycle lag.
REQ-024 WAIT_RISE SHALL go to MEASURE on synchronised sig=1; after T_START_TO cycles without it, SHALL set timeout[ch]=1, leave out_data[ch] unchanged, and go to GAP.
REQ-025 MEASURE SHALL count cycles with synchronised sig=1; on sig=0 it SHALL load the count into out_data[ch] and clear timeout[ch] and ovr[ch].
REQ-026 When the count reaches T_ECHO_MAX, MEASURE SHALL load T_ECHO_MAX into out_data[ch], set ovr[ch]=1, clear timeout[ch], and go to GAP.
REQ-027 The count SHALL be W bits, SHALL saturate, and SHALL never wrap.
REQ-028 GAP SHALL last T_GAP cycles, then NEXT SHALL select the next higher enabled channel.
REQ-029 If no higher enabled channel exists, done SHALL pulse for 1 cycle; with cont=1, a new sweep SHALL start in PULSE on the lowest enabled channel of the resampled ch_mask (IDLE if that mask is 0); with cont=0, the FSM SHALL go to IDLE.
REQ-030 ch_mask changes mid-sweep SHALL NOT affect the current sweep.

Reset
REQ-031 On rst=1, the next edge SHALL give state=IDLE, sig all Z, busy=0, done=0, out_data=0, timeout=0, ovr=0, counters=0.
REQ-032 rst mid-measurement SHALL abort the measurement without updating any result.

Configuration
REQ-033 With macro SONIC_SCANNER_FILTER_EN defined, a successful measurement SHALL update out_data[ch] to (old+new)>>1, computed at W+1 bits; the first success after reset SHALL load new directly.
REQ-034 Without SONIC_SCANNER_FILTER_EN, out_data[ch] SHALL load the new count directly, and no filter state SHALL exist.

Verification (T_PULSE=5, T_HOLDOFF=10, T_START_TO=20, T_ECHO_MAX=100, T_GAP=8, NCH=4)
REQ-035 ch_mask=0001, req pulse, echo high 40 cycles -> sig[0] high exactly 5 cycles, out_data[0]=40, done pulses once, busy returns to 0.
REQ-036 ch_mask=1010, req, no echo on channel 1 -> timeout=0010; channel 3 measured; channels 0 and 2 never driven.
REQ-037 Echo held high 500 cycles -> out_data[ch]=100, ovr[ch]=1, FSM reaches GAP after the saturation cycle.
REQ-038 cont=1, ch_mask=0001 -> back-to-back sweeps, done every sweep; cont dropped -> IDLE after the current sweep.
REQ-039 rst asserted in MEASURE -> sig Z and all outputs 0 on the next edge; the old result is not loaded.
REQ-040 FILTER_EN: echoes of 40 then 60 -> out_data[0]=40, then 50.
